// File: rtl/conv_accel_driver.sv
// Host-side master for the ConvolutionAccelerator: serialises operand words into the
// accelerator FIFO, starts a job, and returns the captured result on a valid/ready port.
module conv_accel_driver #(
  parameter int BIT_LENGTH     = 16,
  parameter int WORDS_PER_JOB  = 18,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [BIT_LENGTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [BIT_LENGTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  err_clr,
  output logic [BIT_LENGTH-1:0] dataInput,
  output logic                  wr,
  output logic                  wr_clk,
  output logic                  cStart,
  input  logic [BIT_LENGTH-1:0] finalsum,
  input  logic                  cReady,
  input  logic                  FULL,
  input  logic                  EMPTY,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           jobs_done
);

  localparam int CNT_W = (WORDS_PER_JOB > 1) ? $clog2(WORDS_PER_JOB) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_JOB - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_STROBE, S_START, S_WAIT, S_RESULT, S_ERROR
  } stateT;

  stateT                 state, stateNext;
  logic [CNT_W-1:0]      wordCnt, wordCntNext;
  logic [TMR_W-1:0]      timer, timerNext;
  logic                  cReadyD;
  logic [BIT_LENGTH-1:0] dataInputNext, mDataNext;
  logic                  wrNext, wrClkNext, cStartNext, mValidNext, errNext;
  logic [15:0]           jobsDoneNext;

  // FIFO status is informational only; the FULL flag alone gates writes.
  logic unusedEmpty;
  assign unusedEmpty = EMPTY;

  assign s_ready = (state == S_LOAD) & ~FULL & ~Rst;
  assign busy    = ~((state == S_LOAD) && (wordCnt == '0));

  always_comb begin
    stateNext     = state;
    wordCntNext   = wordCnt;
    timerNext     = timer;
    dataInputNext = dataInput;
    wrNext        = 1'b0;
    wrClkNext     = 1'b0;
    cStartNext    = 1'b0;
    mDataNext     = m_data;
    mValidNext    = m_valid;
    errNext       = err;
    jobsDoneNext  = jobs_done;
    unique case (state)
      S_LOAD: begin
        if (s_valid && s_ready) begin
          dataInputNext = s_data;
          wrNext        = 1'b1;
          wrClkNext     = 1'b1;
          stateNext     = S_STROBE;
        end
      end
      S_STROBE: begin
        if (wordCnt == LAST_WORD) begin
          wordCntNext = '0;
          cStartNext  = 1'b1;
          stateNext   = S_START;
        end else begin
          wordCntNext = wordCnt + 1'b1;
          stateNext   = S_LOAD;
        end
      end
      S_START: begin
        timerNext = '0;
        stateNext = S_WAIT;
      end
      S_WAIT: begin
        // Only a fresh rising edge counts; a level left over from a previous job is ignored.
        if (cReady && !cReadyD) begin
          mDataNext  = finalsum;
          mValidNext = 1'b1;
          stateNext  = S_RESULT;
        end else if (timer == LAST_TICK) begin
          errNext   = 1'b1;
          stateNext = S_ERROR;
        end else begin
          timerNext = timer + 1'b1;
        end
      end
      S_RESULT: begin
        if (m_ready) begin
          mValidNext   = 1'b0;
          jobsDoneNext = jobs_done + 16'd1;
          stateNext    = S_LOAD;
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          errNext     = 1'b0;
          wordCntNext = '0;
          stateNext   = S_LOAD;
        end
      end
      default: stateNext = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_LOAD;
      wordCnt   <= '0;
      timer     <= '0;
      cReadyD   <= 1'b0;
      dataInput <= '0;
      wr        <= 1'b0;
      wr_clk    <= 1'b0;
      cStart    <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      err       <= 1'b0;
      jobs_done <= '0;
    end else begin
      state     <= stateNext;
      wordCnt   <= wordCntNext;
      timer     <= timerNext;
      cReadyD   <= cReady;
      dataInput <= dataInputNext;
      wr        <= wrNext;
      wr_clk    <= wrClkNext;
      cStart    <= cStartNext;
      m_data    <= mDataNext;
      m_valid   <= mValidNext;
      err       <= errNext;
      jobs_done <= jobsDoneNext;
    end
  end

endmodule

// File: tb/tb_conv_accel_driver.sv
// Scoreboard bench for conv_accel_driver: directed jobs push expected words/results,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_conv_accel_driver;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        err_clr;
  logic [15:0] dataInput;
  logic        wr;
  logic        wr_clk;
  logic        cStart;
  logic [15:0] finalsum;
  logic        cReady;
  logic        FULL;
  logic        EMPTY;
  logic        busy;
  logic        err;
  logic [15:0] jobs_done;

  conv_accel_driver #(
    .BIT_LENGTH(16), .WORDS_PER_JOB(18), .TIMEOUT_CYCLES(64)
  ) dut (
    .Clk(Clk), .Rst(Rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .err_clr(err_clr),
    .dataInput(dataInput), .wr(wr), .wr_clk(wr_clk), .cStart(cStart),
    .finalsum(finalsum), .cReady(cReady), .FULL(FULL), .EMPTY(EMPTY),
    .busy(busy), .err(err), .jobs_done(jobs_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] sum;
    int          cyc;
  } resT;

  logic [15:0] expWordQ[$];
  resT         expResQ[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;
  int cStartCnt = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected none (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: compares strobes, start pulses and results against the scoreboard.
  int          wordsInJob = 0;
  logic        prevWrClk = 1'b0;
  logic        prevMValid = 1'b0;
  logic        prevTook = 1'b0;
  logic [15:0] prevMData = '0;
  always @(negedge Clk) begin
    if (Rst) begin
      wordsInJob = 0;
      prevWrClk  = 1'b0;
      prevMValid = 1'b0;
      prevTook   = 1'b0;
    end else begin
      if (wr_clk) begin
        chk("wr_clk_single", {31'd0, prevWrClk}, 32'd0);
        chk("wr_with_strobe", {31'd0, wr}, 32'd1);
        if (expWordQ.size() == 0) failNow("unexpected_strobe", "strobe");
        else begin
          logic [15:0] w;
          w = expWordQ.pop_front();
          chk("strobe_data", {16'd0, dataInput}, {16'd0, w});
          $display("write word 0x%04h", dataInput);
        end
        wordsInJob++;
      end
      if (cStart) begin
        chk("cstart_after_strobe", {31'd0, prevWrClk}, 32'd1);
        chk("cstart_word_count", wordsInJob, 32'd18);
        wordsInJob = 0;
        startCyc   = cyc;
        cStartCnt++;
        $display("job start at cycle %0d", cyc);
      end
      if (m_valid && !prevMValid) begin
        if (expResQ.size() == 0) failNow("unexpected_result", "m_valid");
        else chk("result_latency", cyc, expResQ[0].cyc);
      end
      if (m_valid && prevMValid && !prevTook)
        chk("result_hold", {16'd0, m_data}, {16'd0, prevMData});
      if (m_valid && m_ready) begin
        if (expResQ.size() == 0) failNow("unexpected_handshake", "handshake");
        else begin
          resT r;
          r = expResQ.pop_front();
          chk("result_data", {16'd0, m_data}, {16'd0, r.sum});
          $display("result 0x%04h consumed", m_data);
        end
      end
      prevWrClk  = wr_clk;
      prevMValid = m_valid;
      prevTook   = m_valid & m_ready;
      prevMData  = m_data;
    end
  end

  task automatic sendWord(input logic [15:0] w, output int waits);
    s_valid = 1'b1;
    s_data  = w;
    waits   = 0;
    @(negedge Clk);
    while (!s_ready && waits < 200) begin
      waits++;
      @(negedge Clk);
    end
    if (!s_ready) failNow("send_timeout", "no s_ready");
    else expWordQ.push_back(w);
    @(posedge Clk); #1;
  endtask

  task automatic sendJob(input logic [15:0] base, input int n);
    int w;
    for (int i = 1; i <= n; i++) sendWord(base + 16'(i), w);
    s_valid = 1'b0;
  endtask

  task automatic waitCStart();
    int n = 0;
    @(negedge Clk);
    while (!cStart && n < 100) begin
      n++;
      @(negedge Clk);
    end
    if (!cStart) failNow("cstart_timeout", "no cStart");
  endtask

  task automatic respond(input int delay, input logic [15:0] sum);
    resT r;
    waitCStart();
    repeat (delay) @(posedge Clk);
    #1;
    finalsum = sum;
    cReady   = 1'b1;
    r.sum = sum;
    r.cyc = cyc + 1;
    expResQ.push_back(r);
  endtask

  task automatic finishResult(input logic [15:0] expJobs);
    int n = 0;
    @(negedge Clk);
    while (!(m_valid && m_ready) && n < 200) begin
      n++;
      @(negedge Clk);
    end
    if (!(m_valid && m_ready)) failNow("result_timeout", "no handshake");
    @(posedge Clk); #1;
    cReady = 1'b0;
    @(negedge Clk);
    chk("jobs_done", {16'd0, jobs_done}, {16'd0, expJobs});
    chk("m_valid_cleared", {31'd0, m_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    @(posedge Clk); #1;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"}, {16'd0, m_data}, 32'd0);
    chk({tag, "_dataInput"}, {16'd0, dataInput}, 32'd0);
    chk({tag, "_wr"}, {31'd0, wr}, 32'd0);
    chk({tag, "_wr_clk"}, {31'd0, wr_clk}, 32'd0);
    chk({tag, "_cStart"}, {31'd0, cStart}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_jobs_done"}, {16'd0, jobs_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    Rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; err_clr = 1'b0;
    finalsum = '0; cReady = 1'b0; FULL = 1'b0; EMPTY = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    checkAllZero("reset");
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("s_ready_after_reset", {31'd0, s_ready}, 32'd1);
    @(posedge Clk); #1;

    // Job 1: back-to-back load, one word per two cycles.
    for (int i = 1; i <= 18; i++) begin
      sendWord(16'(i), w);
      if (i > 1) chk("b2b_gap", w, 32'd1);
    end
    s_valid = 1'b0;
    respond(10, 16'h1234);
    finishResult(16'd1);

    // Job 2: FIFO FULL after the 5th strobe, then held result.
    sendJob(16'd100, 5);
    @(posedge Clk); #1;
    FULL = 1'b1;
    s_valid = 1'b1;
    s_data = 16'd106;
    repeat (7) begin
      @(negedge Clk);
      chk("full_s_ready", {31'd0, s_ready}, 32'd0);
      chk("full_wr_clk", {31'd0, wr_clk}, 32'd0);
      chk("full_wr", {31'd0, wr}, 32'd0);
      @(posedge Clk); #1;
    end
    FULL = 1'b0;
    sendWord(16'd106, w);
    chk("accept_on_full_drop", w, 32'd0);
    sendJob(16'd106, 12);
    m_ready = 1'b0;
    respond(4, 16'h5A5A);
    n = 0;
    @(negedge Clk);
    while (!m_valid && n < 100) begin
      n++;
      @(negedge Clk);
    end
    if (!m_valid) failNow("m_valid_timeout", "no m_valid");
    @(posedge Clk); #1;
    s_valid = 1'b1;
    s_data = 16'h7777;
    repeat (20) begin
      @(negedge Clk);
      chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
      chk("hold_m_valid", {31'd0, m_valid}, 32'd1);
      @(posedge Clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    finishResult(16'd2);

    // Job 3: accelerator never answers.
    sendJob(16'd200, 18);
    waitCStart();
    n = 0;
    @(negedge Clk);
    while (!err && n < 200) begin
      n++;
      @(negedge Clk);
    end
    chk("err_raised", {31'd0, err}, 32'd1);
    chk("err_timing", cyc, startCyc + 65);
    $display("timeout error at cycle %0d", cyc);
    @(posedge Clk); #1;
    s_valid = 1'b1;
    s_data = 16'hAAAA;
    repeat (5) begin
      @(negedge Clk);
      chk("error_s_ready", {31'd0, s_ready}, 32'd0);
      chk("error_wr_clk", {31'd0, wr_clk}, 32'd0);
      chk("error_err", {31'd0, err}, 32'd1);
      @(posedge Clk); #1;
    end
    s_valid = 1'b0;
    err_clr = 1'b1;
    @(posedge Clk); #1;
    err_clr = 1'b0;
    @(negedge Clk);
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_s_ready", {31'd0, s_ready}, 32'd1);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_jobs_done", {16'd0, jobs_done}, 32'd2);
    @(posedge Clk); #1;

    // Job 4: cReady already high before the start pulse.
    sendJob(16'd300, 10);
    finalsum = 16'hDEAD;
    cReady = 1'b1;
    sendJob(16'd310, 8);
    waitCStart();
    repeat (3) @(posedge Clk);
    #1;
    cReady = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    begin
      resT r;
      finalsum = 16'hBEEF;
      cReady = 1'b1;
      r.sum = 16'hBEEF;
      r.cyc = cyc + 1;
      expResQ.push_back(r);
    end
    finishResult(16'd3);

    // Reset after 7 words, then a complete fresh job.
    sendJob(16'd400, 7);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    checkAllZero("midreset");
    @(posedge Clk); #1;
    Rst = 1'b0;
    sendJob(16'd500, 18);
    respond(6, 16'h0F0F);
    finishResult(16'd1);

    repeat (3) @(posedge Clk);
    #1;
    chk("word_queue_empty", expWordQ.size(), 32'd0);
    chk("result_queue_empty", expResQ.size(), 32'd0);
    chk("cstart_total", cStartCnt, 32'd5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
